// File: rtl/fht_io_sequencer.sv
// fht_io_sequencer: frame sequencer for the FHT core. It loads one frame
// into the four data banks, starts the engine, waits for it, then unloads.
// Optional macro FHT_SEQ_BITREV_EN: when defined, the load index is the
// bit-reversed sample count; when undefined, frames load in natural order.
// Ports:
//   iCLK, iRESET          clock, asynchronous active-high reset
//   iDATA/iVALID/oREADY   input sample stream
//   oDATA/oVALID/iREADY   output sample stream, oLAST on sample N-1
//   oFHT_START, iFHT_RDY  engine start pulse and idle flag
//   oBANK_*               bank port (owned by sequencer when oBANK_OWN=1)
//   iBANK_RDATA           bank read data, one cycle after address
//   oBUSY                 high in every state except IDLE
module fht_io_sequencer #(
    parameter int A_BIT = 8,
    parameter int D_BIT = 16
) (
    input  logic             iCLK,
    input  logic             iRESET,
    input  logic [D_BIT-1:0] iDATA,
    input  logic             iVALID,
    output logic             oREADY,
    output logic [D_BIT-1:0] oDATA,
    output logic             oVALID,
    input  logic             iREADY,
    output logic             oLAST,
    output logic             oFHT_START,
    input  logic             iFHT_RDY,
    output logic             oBANK_OWN,
    output logic [1:0]       oBANK_SEL,
    output logic [A_BIT-1:0] oBANK_ADDR,
    output logic             oBANK_WE,
    output logic [D_BIT-1:0] oBANK_WDATA,
    input  logic [D_BIT-1:0] iBANK_RDATA,
    output logic             oBUSY
);

    localparam int K_W = A_BIT + 2;
    localparam logic [K_W-1:0] K_LAST = {K_W{1'b1}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_RUN,
        S_UNLOAD
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [K_W-1:0] k_cnt;
    logic [K_W-1:0] r_cnt;
    logic [K_W-1:0] o_cnt;
    logic [K_W-1:0] j_idx;
    logic           r_done;
    logic           seen_busy;
    logic           rd_pend;

    logic [D_BIT-1:0] fifo_mem [2];
    logic             fifo_wp;
    logic             fifo_rp;
    logic [1:0]       fifo_cnt;

    logic       load_ph;
    logic       beat;
    logic       xfer;
    logic       issue;
    logic [2:0] occ;

`ifdef FHT_SEQ_BITREV_EN
    function automatic logic [K_W-1:0] bitrev(input logic [K_W-1:0] v);
        logic [K_W-1:0] res;
        for (int i = 0; i < K_W; i++) begin
            res[i] = v[K_W-1-i];
        end
        return res;
    endfunction

    assign j_idx = bitrev(k_cnt);
`else
    assign j_idx = k_cnt;
`endif

    assign load_ph = (state == S_IDLE) || (state == S_LOAD);
    // Gate with reset so the bank port shows no write while reset is held.
    assign beat    = load_ph & iVALID & ~iRESET;

    assign oVALID  = (fifo_cnt != 2'd0);
    assign oDATA   = fifo_mem[fifo_rp];
    assign xfer    = oVALID & iREADY;
    assign oLAST   = oVALID & (state == S_UNLOAD) & (o_cnt == K_LAST);
    assign oBUSY   = (state != S_IDLE);

    // Occupancy counts the head leaving this cycle as already gone, so a
    // read can be issued every cycle while the consumer keeps up.
    assign occ   = {1'b0, fifo_cnt} + {2'b00, rd_pend} - {2'b00, xfer};
    assign issue = (state == S_UNLOAD) & ~r_done & (occ < 3'd2);

    always_comb begin
        state_nxt   = state;
        oREADY      = 1'b0;
        oBANK_OWN   = 1'b1;
        oFHT_START  = 1'b0;
        oBANK_WE    = 1'b0;
        oBANK_SEL   = 2'd0;
        oBANK_ADDR  = '0;
        oBANK_WDATA = '0;
        unique case (state)
            S_IDLE, S_LOAD: begin
                oREADY = 1'b1;
                if (beat) begin
                    oBANK_WE    = 1'b1;
                    oBANK_WDATA = iDATA;
                    oBANK_SEL   = j_idx[1:0];
                    oBANK_ADDR  = j_idx[K_W-1:2];
                    if (k_cnt == K_LAST) begin
                        state_nxt = S_START;
                    end else begin
                        state_nxt = S_LOAD;
                    end
                end
            end
            S_START: begin
                oFHT_START = 1'b1;
                oBANK_OWN  = 1'b0;
                state_nxt  = S_RUN;
            end
            S_RUN: begin
                oBANK_OWN = 1'b0;
                // Wait for the engine to go busy and come back idle.
                if (seen_busy && iFHT_RDY) begin
                    state_nxt = S_UNLOAD;
                end
            end
            S_UNLOAD: begin
                oBANK_SEL  = r_cnt[1:0];
                oBANK_ADDR = r_cnt[K_W-1:2];
                if (xfer && (o_cnt == K_LAST)) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge iCLK or posedge iRESET) begin
        if (iRESET) begin
            state     <= S_IDLE;
            k_cnt     <= '0;
            r_cnt     <= '0;
            o_cnt     <= '0;
            r_done    <= 1'b0;
            seen_busy <= 1'b0;
            rd_pend   <= 1'b0;
            fifo_wp   <= 1'b0;
            fifo_rp   <= 1'b0;
            fifo_cnt  <= 2'd0;
        end else begin
            state   <= state_nxt;
            rd_pend <= issue;
            if (beat) begin
                k_cnt <= k_cnt + 1'b1;
            end
            if (state == S_RUN) begin
                if (!iFHT_RDY) begin
                    seen_busy <= 1'b1;
                end
            end else begin
                seen_busy <= 1'b0;
            end
            if (issue) begin
                r_cnt <= r_cnt + 1'b1;
                if (r_cnt == K_LAST) begin
                    r_done <= 1'b1;
                end
            end
            if (rd_pend) begin
                fifo_wp <= ~fifo_wp;
            end
            if (xfer) begin
                fifo_rp <= ~fifo_rp;
                o_cnt   <= o_cnt + 1'b1;
            end
            fifo_cnt <= fifo_cnt + {1'b0, rd_pend} - {1'b0, xfer};
            if ((state == S_UNLOAD) && (state_nxt == S_IDLE)) begin
                r_done <= 1'b0;
            end
        end
    end

    always_ff @(posedge iCLK) begin
        if (rd_pend) begin
            fifo_mem[fifo_wp] <= iBANK_RDATA;
        end
    end

endmodule

// File: tb/tb_fht_io_sequencer.sv
// tb_fht_io_sequencer: bench for fht_io_sequencer with a bank RAM model,
// an engine model and a frame-level reference of load placement and output.
module tb_fht_io_sequencer;

    localparam int A_BIT = 8;
    localparam int D_BIT = 16;
    localparam int K_W   = A_BIT + 2;
    localparam int N     = 1 << K_W;

    logic             iCLK = 1'b0;
    logic             iRESET;
    logic [D_BIT-1:0] iDATA;
    logic             iVALID;
    logic             oREADY;
    logic [D_BIT-1:0] oDATA;
    logic             oVALID;
    logic             iREADY;
    logic             oLAST;
    logic             oFHT_START;
    logic             iFHT_RDY;
    logic             oBANK_OWN;
    logic [1:0]       oBANK_SEL;
    logic [A_BIT-1:0] oBANK_ADDR;
    logic             oBANK_WE;
    logic [D_BIT-1:0] oBANK_WDATA;
    logic [D_BIT-1:0] iBANK_RDATA;
    logic             oBUSY;

    int total = 0;
    int bad   = 0;
    int start_pulses = 0;
    int snap;

    logic [D_BIT-1:0] mem     [0:N-1];
    logic [D_BIT-1:0] exp_out [0:N-1];

    always #5 iCLK = ~iCLK;

    fht_io_sequencer #(.A_BIT(A_BIT), .D_BIT(D_BIT)) dut (
        .iCLK(iCLK), .iRESET(iRESET),
        .iDATA(iDATA), .iVALID(iVALID), .oREADY(oREADY),
        .oDATA(oDATA), .oVALID(oVALID), .iREADY(iREADY), .oLAST(oLAST),
        .oFHT_START(oFHT_START), .iFHT_RDY(iFHT_RDY),
        .oBANK_OWN(oBANK_OWN), .oBANK_SEL(oBANK_SEL),
        .oBANK_ADDR(oBANK_ADDR), .oBANK_WE(oBANK_WE),
        .oBANK_WDATA(oBANK_WDATA), .iBANK_RDATA(iBANK_RDATA),
        .oBUSY(oBUSY)
    );

    // Four banks flattened as {addr, bank}; synchronous read.
    always @(posedge iCLK) begin
        if (oBANK_OWN && oBANK_WE) mem[{oBANK_ADDR, oBANK_SEL}] <= oBANK_WDATA;
        iBANK_RDATA <= mem[{oBANK_ADDR, oBANK_SEL}];
    end

    always @(posedge iCLK) begin
        if (oFHT_START && !iRESET) start_pulses <= start_pulses + 1;
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h at %0t", nm, act, expv, $time);
        end
    endtask

    function automatic int pos_of(input int k);
`ifdef FHT_SEQ_BITREV_EN
        int j = 0;
        int t = k;
        for (int i = 0; i < K_W; i++) begin
            j = j * 2 + t % 2;
            t = t / 2;
        end
        return j;
`else
        return k;
`endif
    endfunction

    task automatic check_reset(input string tg);
        chk({tg, "_rdy"},   32'(oREADY), 1);
        chk({tg, "_own"},   32'(oBANK_OWN), 1);
        chk({tg, "_vld"},   32'(oVALID), 0);
        chk({tg, "_last"},  32'(oLAST), 0);
        chk({tg, "_start"}, 32'(oFHT_START), 0);
        chk({tg, "_we"},    32'(oBANK_WE), 0);
        chk({tg, "_busy"},  32'(oBUSY), 0);
        chk({tg, "_sel"},   32'(oBANK_SEL), 0);
        chk({tg, "_addr"},  32'(oBANK_ADDR), 0);
        chk({tg, "_wd"},    32'(oBANK_WDATA), 0);
    endtask

    task automatic load_frame(input bit rnd, input int abort_at);
        int k;
        int p;
        logic [D_BIT-1:0] d;
        k = 0;
        while (k < N) begin
            @(posedge iCLK);
            #1;
            if (rnd && $urandom_range(0, 3) == 0) begin
                iVALID = 1'b0;
                iDATA  = D_BIT'($urandom);
                @(negedge iCLK);
                chk("gap_we",  32'(oBANK_WE), 0);
                chk("gap_rdy", 32'(oREADY), 1);
            end else begin
                d = rnd ? D_BIT'($urandom) : D_BIT'(k);
                iVALID = 1'b1;
                iDATA  = d;
                p = pos_of(k);
                @(negedge iCLK);
                if (k == abort_at) begin
                    iRESET = 1'b1;
                    #1;
                    check_reset("midrst");
                    @(posedge iCLK);
                    #1;
                    iRESET = 1'b0;
                    iVALID = 1'b0;
                    return;
                end
                chk("ld_rdy",  32'(oREADY), 1);
                chk("ld_we",   32'(oBANK_WE), 1);
                chk("ld_sel",  32'(oBANK_SEL), 32'(p % 4));
                chk("ld_addr", 32'(oBANK_ADDR), 32'(p / 4));
                chk("ld_wd",   32'(oBANK_WDATA), 32'(d));
                exp_out[p] = d;
                k++;
            end
        end
        @(posedge iCLK);
        #1;
        iVALID = 1'b0;
    endtask

    task automatic start_check();
        @(negedge iCLK);
        chk("st_pulse", 32'(oFHT_START), 1);
        chk("st_rdy",   32'(oREADY), 0);
        chk("st_own",   32'(oBANK_OWN), 0);
        chk("st_busy",  32'(oBUSY), 1);
        @(negedge iCLK);
        chk("st_once",  32'(oFHT_START), 0);
        chk("st_own2",  32'(oBANK_OWN), 0);
    endtask

    task automatic engine(input int hi_first, input int lo_cycles);
        iFHT_RDY = 1'b1;
        repeat (hi_first) begin
            @(negedge iCLK);
            chk("run_own",  32'(oBANK_OWN), 0);
            chk("run_vld",  32'(oVALID), 0);
            chk("run_rdy",  32'(oREADY), 0);
        end
        @(posedge iCLK);
        #1;
        iFHT_RDY = 1'b0;
        repeat (lo_cycles) @(posedge iCLK);
        #1;
        iFHT_RDY = 1'b1;
        @(negedge iCLK);
        chk("run_last_own", 32'(oBANK_OWN), 0);
        @(negedge iCLK);
        chk("ul_own", 32'(oBANK_OWN), 1);
        chk("ul_vld0", 32'(oVALID), 0);
        chk("ul_we", 32'(oBANK_WE), 0);
        @(negedge iCLK);
        chk("ul_vld1", 32'(oVALID), 0);
    endtask

    task automatic unload(input bit rnd);
        int o = 0;
        int cyc = 0;
        logic pv = 1'b0;
        logic pr = 1'b0;
        logic [D_BIT-1:0] pd = '0;
        while (o < N && cyc < 8 * N) begin
            @(posedge iCLK);
            #1;
            iREADY = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge iCLK);
            if (cyc == 0) chk("lat_vld", 32'(oVALID), 1);
            if (pv && !pr) begin
                chk("stall_vld", 32'(oVALID), 1);
                chk("stall_dat", 32'(oDATA), 32'(pd));
            end
            if (oVALID) begin
                chk("out_dat",  32'(oDATA), 32'(exp_out[o]));
                chk("out_last", 32'(oLAST), 32'(o == N - 1));
                if (iREADY) o++;
            end else begin
                chk("idle_last", 32'(oLAST), 0);
            end
            pv = oVALID;
            pr = iREADY;
            pd = oDATA;
            cyc++;
        end
        if (o != N) chk("unload_timeout", 32'(o), 32'(N));
        else if (!rnd) chk("thruput", 32'(cyc), 32'(N));
        @(posedge iCLK);
        #1;
        iREADY = 1'b0;
        @(negedge iCLK);
        chk("end_busy", 32'(oBUSY), 0);
        chk("end_rdy",  32'(oREADY), 1);
        chk("end_own",  32'(oBANK_OWN), 1);
        chk("end_vld",  32'(oVALID), 0);
    endtask

    initial begin
        iRESET   = 1'b1;
        iVALID   = 1'b1;
        iDATA    = 16'h1234;
        iREADY   = 1'b0;
        iFHT_RDY = 1'b1;
        #12;
        check_reset("rst");
        @(posedge iCLK);
        #1;
        iRESET = 1'b0;
        iVALID = 1'b0;
        @(negedge iCLK);
        chk("post_rst_busy", 32'(oBUSY), 0);

        snap = start_pulses;
        load_frame(1'b0, -1);
        start_check();
`ifdef FHT_SEQ_BITREV_EN
        chk("lit_k1",  32'(mem[{8'd128, 2'd0}]), 1);
        chk("lit_k2",  32'(mem[{8'd64, 2'd0}]), 2);
        chk("model_o1", 32'(exp_out[1]), 512);
`else
        chk("lit_k1",  32'(mem[{8'd0, 2'd1}]), 1);
        chk("lit_k4",  32'(mem[{8'd1, 2'd0}]), 4);
        chk("model_o1", 32'(exp_out[1]), 1);
`endif
        chk("lit_k1023", 32'(mem[{8'd255, 2'd3}]), 1023);
        chk("model_o0", 32'(exp_out[0]), 0);
        engine(20, 5700);
        unload(1'b0);
        chk("pulses_a", 32'(start_pulses - snap), 1);

        load_frame(1'b1, 300);
        @(negedge iCLK);
        chk("rst_idle_busy", 32'(oBUSY), 0);
        chk("rst_idle_rdy",  32'(oREADY), 1);
        snap = start_pulses;
        load_frame(1'b1, -1);
        start_check();
        engine(3, 50);
        unload(1'b1);
        chk("pulses_b", 32'(start_pulses - snap), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
